// File: rtl/arm_pkg.sv
// Shared ARM datapath definitions: width helper common with Delay_Gen and the
// sequencer state encoding.
package arm_pkg;

  // floor(log2(v)); returns 0 for v <= 1
  function automatic int unsigned log2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = v;
    while (x > 1) begin
      x = x >> 1;
      r++;
    end
    return r;
  endfunction

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_FLUSH = 2'd3;

  typedef enum logic [1:0] {
    StIdle  = ST_IDLE,
    StWait  = ST_WAIT,
    StHold  = ST_HOLD,
    StFlush = ST_FLUSH
  } seq_state_e;

endpackage

// File: rtl/delay_op_sequencer.sv
// Valid/ready front-end that runs the sibling Delay_Gen for one full period per
// payload and releases the payload when the count wraps.
module delay_op_sequencer
  import arm_pkg::*;
#(
  parameter int unsigned DW     = 8,
  parameter int unsigned DATA_W = 32,
  localparam int unsigned CW    = log2(DW) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              abort,
  output logic              dly_en,
  input  logic [CW-1:0]     dly_cnt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              sync_err
);

  localparam logic [CW-1:0] CntLast = CW'(DW - 1);

  seq_state_e        state_q, state_d;
  logic [DATA_W-1:0] data_q;
  logic              first_q;
  logic              sync_err_q;
  logic              cnt_last;
  logic              accept;

  assign cnt_last = (dly_cnt == CntLast);
  assign accept   = (state_q == StIdle) && in_valid;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid) state_d = StWait;
      // The counter wraps on the exit edge either way, so abort at the last
      // count can drop straight to idle.
      StWait: begin
        if (cnt_last)   state_d = abort ? StIdle : StHold;
        else if (abort) state_d = StFlush;
      end
      StHold:  if (out_ready) state_d = StIdle;
      StFlush: if (cnt_last) state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      data_q     <= '0;
      first_q    <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      first_q <= accept;
      if (accept) data_q <= in_data;
      if ((state_q == StWait) && first_q && (dly_cnt != '0)) sync_err_q <= 1'b1;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign dly_en    = (state_q == StWait) || (state_q == StFlush);
  assign out_valid = (state_q == StHold);
  assign busy      = (state_q != StIdle);
  assign out_data  = data_q;
  assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_delay_op_sequencer.sv
// Self-checking bench for delay_op_sequencer with a behavioural Delay_Gen and a
// transaction-level reference model.
module tb_delay_op_sequencer;

  localparam int unsigned DW     = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CW     = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              abort = 1'b0;
  logic              dly_en;
  logic [CW-1:0]     dly_cnt;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic              busy;
  logic              sync_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Delay_Gen stand-in, with a one-shot load to emulate misalignment
  logic          force_load = 1'b0;
  logic [CW-1:0] force_val  = '0;

  always #5 clk = ~clk;

  delay_op_sequencer #(.DW(DW), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .abort     (abort),
    .dly_en    (dly_en),
    .dly_cnt   (dly_cnt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .sync_err  (sync_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          dly_cnt <= '0;
    else if (force_load) dly_cnt <= force_val;
    else if (dly_en)     dly_cnt <= (int'(dly_cnt) == DW - 1) ? '0 : dly_cnt + 1'b1;
  end

  // Reference model: a payload either is being timed, is being presented, or
  // the block is free. Timing ends on the cycle the counter shows DW-1.
  bit              m_timing, m_present, m_keep, m_first, m_serr;
  logic [DATA_W-1:0] m_payload;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_timing = 0; m_present = 0; m_keep = 0; m_first = 0; m_serr = 0;
      m_payload = '0;
    end else if (m_timing) begin
      if (m_first && dly_cnt != 0) m_serr = 1;
      m_first = 0;
      if (abort) m_keep = 0;
      if (int'(dly_cnt) == DW - 1) begin
        m_timing  = 0;
        m_present = m_keep;
      end
    end else if (m_present) begin
      if (out_ready) m_present = 0;
    end else if (in_valid) begin
      m_payload = in_data;
      m_keep    = 1;
      m_timing  = 1;
      m_first   = 1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("in_ready",  64'(in_ready),  64'(!(m_timing || m_present)));
    check("dly_en",    64'(dly_en),    64'(m_timing));
    check("out_valid", 64'(out_valid), 64'(m_present));
    check("busy",      64'(busy),      64'(m_timing || m_present));
    check("sync_err",  64'(sync_err),  64'(m_serr));
    if (m_present) check("out_data", 64'(out_data), 64'(m_payload));
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  task automatic idle_inputs();
    in_valid = 0; abort = 0; out_ready = 0; force_load = 0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (busy && guard < 40) begin
      step();
      guard++;
    end
    check("wait_idle_timeout", 64'(busy), 64'(0));
  endtask

  task automatic wait_cnt(input int v);
    int guard = 0;
    while (int'(dly_cnt) != v && guard < 20) begin
      step();
      guard++;
    end
    check("wait_cnt_timeout", 64'(dly_cnt), 64'(v));
  endtask

  typedef struct {
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              out_ready;
    logic              exp_in_ready;
    logic              exp_dly_en;
    logic              exp_out_valid;
    logic [CW-1:0]     exp_cnt;
  } vec_t;

  vec_t vecs[10];

  initial begin
    bit saw_ov;
    logic [DATA_W-1:0] held;

    // Nominal transaction, one row per cycle: row k is applied, the edge
    // fires, then the row's expectations are checked.
    vecs[0] = '{1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0};
    for (int i = 1; i < 8; i++)
      vecs[i] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'(i)};
    vecs[8] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0};
    vecs[9] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0};

    // Reset then idle
    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_dly_en", 64'(dly_en), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_sync_err", 64'(sync_err), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    rst_n = 1;
    repeat (10) step();

    // Nominal delay
    for (int i = 0; i < 10; i++) begin
      in_valid = vecs[i].in_valid; in_data = vecs[i].in_data; out_ready = vecs[i].out_ready;
      step();
      check($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].exp_in_ready));
      check($sformatf("vec%0d_dly_en", i), 64'(dly_en), 64'(vecs[i].exp_dly_en));
      check($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].exp_out_valid));
      check($sformatf("vec%0d_cnt", i), 64'(dly_cnt), 64'(vecs[i].exp_cnt));
      if (vecs[i].exp_out_valid) check("vec_out_data", 64'(out_data), 64'(32'hDEADBEEF));
    end
    idle_inputs();

    // Backpressure: out_valid held 6 cycles, then idle after out_ready
    in_valid = 1; in_data = 32'hCAFEF00D;
    step();
    in_valid = 0; in_data = 32'h12345678;
    repeat (8) step();
    check("bp_out_valid_rise", 64'(out_valid), 64'(1));
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_hold_valid", 64'(out_valid), 64'(1));
      check("bp_hold_data", 64'(out_data), 64'(32'hCAFEF00D));
      check("bp_in_ready", 64'(in_ready), 64'(0));
    end
    out_ready = 1;
    step();
    check("bp_release", 64'(in_ready), 64'(1));
    idle_inputs();

    // Abort mid-count
    in_valid = 1; in_data = 32'hA5A5A5A5;
    step();
    in_valid = 0;
    wait_cnt(3);
    abort = 1;
    step();
    abort = 0;
    check("abort_flush_en", 64'(dly_en), 64'(1));
    saw_ov = 0;
    for (int g = 0; g < 20 && busy; g++) begin
      if (out_valid) saw_ov = 1;
      if (g == 1) abort = 1;  // extra pulse in flush is ignored
      else abort = 0;
      step();
    end
    abort = 0;
    check("abort_no_output", 64'(saw_ov), 64'(0));
    check("abort_cnt_rest", 64'(dly_cnt), 64'(0));
    in_valid = 1; in_data = 32'h0BADCAFE;
    step();
    in_valid = 0;
    check("after_abort_cnt0", 64'(dly_cnt), 64'(0));
    step();
    check("after_abort_serr", 64'(sync_err), 64'(0));
    out_ready = 1;
    wait_idle();
    idle_inputs();

    // Abort at the last count
    in_valid = 1; in_data = 32'h77777777;
    step();
    in_valid = 0;
    wait_cnt(7);
    abort = 1;
    step();
    abort = 0;
    check("abort_last_idle", 64'(in_ready), 64'(1));
    check("abort_last_no_ov", 64'(out_valid), 64'(0));

    // Abort during HOLD is ignored
    in_valid = 1; in_data = 32'h5EED5EED;
    step();
    in_valid = 0;
    repeat (8) step();
    abort = 1;
    step();
    check("hold_abort_valid", 64'(out_valid), 64'(1));
    check("hold_abort_data", 64'(out_data), 64'(32'h5EED5EED));
    abort = 0; out_ready = 1;
    step();
    check("hold_abort_done", 64'(in_ready), 64'(1));
    idle_inputs();

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) == 0);
      in_data   = $urandom;
      abort     = ($urandom_range(0, 9) == 0);
      out_ready = ($urandom_range(0, 1) == 1);
      step();
    end
    idle_inputs();
    out_ready = 1;
    wait_idle();

    // Asynchronous reset mid-WAIT
    out_ready = 0;
    in_valid = 1; in_data = 32'hFEEDFACE;
    step();
    in_valid = 0;
    repeat (3) step();
    #2 rst_n = 0;
    #1;
    check("areset_in_ready", 64'(in_ready), 64'(1));
    check("areset_dly_en", 64'(dly_en), 64'(0));
    check("areset_out_data", 64'(out_data), 64'(0));
    @(negedge clk);
    rst_n = 1;
    step();

    // Misalignment: counter at 5 on WAIT entry
    force_val = 4'd5; force_load = 1;
    step();
    force_load = 0;
    in_valid = 1; in_data = 32'h0000BEEF;
    step();
    in_valid = 0;
    check("mis_cnt", 64'(dly_cnt), 64'(5));
    step();
    check("mis_sync_err", 64'(sync_err), 64'(1));
    out_ready = 1;
    wait_idle();
    in_valid = 1; in_data = 32'h11112222;
    step();
    in_valid = 0;
    wait_idle();
    check("mis_sticky", 64'(sync_err), 64'(1));
    held = out_data;
    check("mis_payload_latched", 64'(held), 64'(32'h11112222));
    rst_n = 0;
    @(negedge clk);
    check("mis_cleared", 64'(sync_err), 64'(0));
    rst_n = 1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
